seg_disp_sched: RTL and testbench

- Time-shares the three-digit seven-segment display between N_SRC value producers: input angle, CORDIC sine result and CORDIC cosine result.
- Round-robin scheduler with a dwell timer, feeding a sequential double-dabble binary-to-BCD engine. No combinational dividers.
- Outputs registered BCD digits (ones/tens/hundreds) that drive the existing per-digit segment decoders.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_bin2bcd.sv | 63 ++++++
 rtl/seg_disp_sched.sv | 146 ++++++++++++++
 tb/tb_seg_disp_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, SELECT, CONVERT, SHOW} state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t d2;
        bcd_t d1;
        bcd_t d0;
    } bcd3_t;

    localparam bcd_t BLANK_CODE = 4'hF;
    localparam int   MAX_DISP   = 999;

    // Replace leading zero digits with the dark code; the ones digit always shows.
    function automatic bcd3_t lz_blank(input bcd3_t d);
        bcd3_t r;
        r = d;
        if (d.d2 == 4'd0)
            r.d2 = BLANK_CODE;
        if (d.d2 == 4'd0 && d.d1 == 4'd0)
            r.d1 = BLANK_CODE;
        return r;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble binary-to-BCD core; WIDTH shift cycles after start,
// then a one-cycle done pulse with the result held on dout. Input must be <= 999.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             done,
    output bcd3_t            dout
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    sh;
    logic [11:0]         acc;
    logic [11:0]         adj;
    logic [12+WIDTH-1:0] nxt;
    logic [CW-1:0]       cnt;
    logic                run;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        adj = acc;
        for (int d = 0; d < 3; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        nxt = {adj, sh} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh  <= din;
                acc <= '0;
                cnt <= CW'(WIDTH);
                run <= 1'b1;
            end else if (run) begin
                acc <= nxt[WIDTH +: 12];
                sh  <= nxt[WIDTH-1:0];
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign dout = bcd3_t'(acc);

endmodule

// File: rtl/seg_disp_sched.sv
// Round-robin time-share of the 3-digit display between N_SRC producers.
// Optional SEG_LZ_BLANK_EN: leading zero digits are driven as the dark code.
module seg_disp_sched
    import seg_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int WIDTH     = 10,
    parameter int DWELL_CYC = 50000000,
    parameter int SRC_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_vld,
    input  logic [N_SRC*WIDTH-1:0] src_val,
    input  logic                   hold,
    output logic [3:0]             bcd0,
    output logic [3:0]             bcd1,
    output logic [3:0]             bcd2,
    output logic [SRC_W-1:0]       disp_src,
    output logic                   disp_upd,
    output logic                   ovf,
    output logic                   busy
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    state_t                       state, state_nx;
    logic [N_SRC-1:0][WIDTH-1:0]  hold_q;
    logic [N_SRC-1:0]             vld_q;
    logic [SRC_W-1:0]             cur_src;
    logic [SRC_W-1:0]             pick;
    logic                         ovf_pend;
    logic [DW-1:0]                dwell_cnt;
    logic                         sat;
    logic [WIDTH-1:0]             conv_val;
    logic                         conv_start;
    logic                         core_done;
    bcd3_t                        core_dout;
    bcd3_t                        shown;

    // Next source: first valid one after the displayed index, wrapping; hold keeps it.
    always_comb begin
        logic found;
        int   idx;
        pick  = disp_src;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = int'(disp_src) + k;
            if (idx >= N_SRC)
                idx = idx - N_SRC;
            if (!found && vld_q[idx]) begin
                pick  = SRC_W'(idx);
                found = 1'b1;
            end
        end
        if (hold && vld_q[disp_src])
            pick = disp_src;
    end

    always_comb begin
        sat        = int'(hold_q[pick]) > MAX_DISP;
        conv_val   = sat ? WIDTH'(MAX_DISP) : hold_q[pick];
        conv_start = (state == SELECT);
    end

    always_comb begin
`ifdef SEG_LZ_BLANK_EN
        shown = lz_blank(core_dout);
`else
        shown = core_dout;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|vld_q) state_nx = SELECT;
            SELECT:  state_nx = CONVERT;
            CONVERT: if (core_done) state_nx = SHOW;
            SHOW:    if (dwell_cnt == DW'(DWELL_CYC - 1)) state_nx = SELECT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_q    <= '0;
            vld_q     <= '0;
            cur_src   <= '0;
            ovf_pend  <= 1'b0;
            dwell_cnt <= '0;
            bcd0      <= '0;
            bcd1      <= '0;
            bcd2      <= '0;
            disp_src  <= '0;
            disp_upd  <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state    <= state_nx;
            disp_upd <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                if (src_vld[i]) begin
                    hold_q[i] <= src_val[i*WIDTH +: WIDTH];
                    vld_q[i]  <= 1'b1;
                end
            end
            case (state)
                SELECT: begin
                    cur_src  <= pick;
                    ovf_pend <= sat;
                    busy     <= 1'b1;
                end
                CONVERT: begin
                    // Digits, index and overflow flag change together on this edge.
                    if (core_done) begin
                        bcd2      <= shown.d2;
                        bcd1      <= shown.d1;
                        bcd0      <= shown.d0;
                        disp_src  <= cur_src;
                        ovf       <= ovf_pend;
                        disp_upd  <= 1'b1;
                        busy      <= 1'b0;
                        dwell_cnt <= '0;
                    end
                end
                SHOW: begin
                    if (dwell_cnt != '1)
                        dwell_cnt <= dwell_cnt + DW'(1);
                end
                default: ;
            endcase
        end
    end

    seg_bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .din   (conv_val),
        .done  (core_done),
        .dout  (core_dout)
    );

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: table of single-source conversions plus sequences for
// rotation, saturation, hold, snapshot and mid-conversion reset.
module tb_seg_disp_sched;

    localparam int N_SRC = 3;
    localparam int WIDTH = 10;
    localparam int DWELL = 20;
    localparam int SRC_W = 2;
    localparam int LAT   = WIDTH + 3;
    localparam int PER   = DWELL + WIDTH + 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_SRC-1:0]       src_vld = '0;
    logic [N_SRC*WIDTH-1:0] src_val = '0;
    logic                   hold = 1'b0;
    logic [3:0]             bcd0, bcd1, bcd2;
    logic [SRC_W-1:0]       disp_src;
    logic                   disp_upd, ovf, busy;

    seg_disp_sched #(.N_SRC(N_SRC), .WIDTH(WIDTH), .DWELL_CYC(DWELL), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst(rst), .src_vld(src_vld), .src_val(src_val), .hold(hold),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .disp_src(disp_src),
        .disp_upd(disp_upd), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int src; int d2; int d1; int d0; int ovf; } sb_t;
    typedef struct { int val; int e2; int e1; int e0; int eovf; } vec_t;

    sb_t sb[$];
    int  n_run = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  upd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_dig(input int src, input int d2, input int d1, input int d0, input int o);
        sb_t e;
        e.src = src; e.d2 = d2; e.d1 = d1; e.d0 = d0; e.ovf = o;
`ifdef SEG_LZ_BLANK_EN
        if (d2 == 0) e.d2 = 15;
        if (d2 == 0 && d1 == 0) e.d1 = 15;
`endif
        sb.push_back(e);
    endfunction

    function automatic void push_val(input int src, input int v);
        int vv;
        vv = (v > 999) ? 999 : v;
        push_dig(src, vv / 100, (vv / 10) % 10, vv % 10, (v > 999) ? 1 : 0);
    endfunction

    // Every display update is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && disp_upd) begin
            sb_t e;
            upd_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_upd", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("upd_src", int'(disp_src), e.src);
                chk("upd_d2", int'(bcd2), e.d2);
                chk("upd_d1", int'(bcd1), e.d1);
                chk("upd_d0", int'(bcd0), e.d0);
                chk("upd_ovf", int'(ovf), e.ovf);
                chk("upd_busy", int'(busy), 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hold = 1'b0; src_vld = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [N_SRC-1:0] m, input int v0, input int v1, input int v2);
        @(negedge clk);
        src_vld = m;
        src_val[0*WIDTH +: WIDTH] = v0[WIDTH-1:0];
        src_val[1*WIDTH +: WIDTH] = v1[WIDTH-1:0];
        src_val[2*WIDTH +: WIDTH] = v2[WIDTH-1:0];
        @(negedge clk);
        src_vld = '0;
    endtask

    task automatic wait_upd(input string nm, output int c);
        c = -1;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (disp_upd) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic chk_sb_empty(input string nm);
        repeat (2) @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int c0, u1, u2, u3, u4;

        vecs[0]  = '{360, 3, 6, 0, 0};
        vecs[1]  = '{0,   0, 0, 0, 0};
        vecs[2]  = '{7,   0, 0, 7, 0};
        vecs[3]  = '{45,  0, 4, 5, 0};
        vecs[4]  = '{99,  0, 9, 9, 0};
        vecs[5]  = '{100, 1, 0, 0, 0};
        vecs[6]  = '{512, 5, 1, 2, 0};
        vecs[7]  = '{999, 9, 9, 9, 0};
        vecs[8]  = '{1000, 9, 9, 9, 1};
        vecs[9]  = '{1023, 9, 9, 9, 1};
        vecs[10] = '{10,  0, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bcd0", int'(bcd0), 0);
        chk("rst_bcd1", int'(bcd1), 0);
        chk("rst_bcd2", int'(bcd2), 0);
        chk("rst_src", int'(disp_src), 0);
        chk("rst_upd", int'(disp_upd), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // First conversion: latency, busy and single-cycle update pulse
        push_val(0, 360);
        load(3'b001, 360, 0, 0);
        c0 = cyc;
        repeat (5) @(negedge clk);
        chk("busy_mid", int'(busy), 1);
        wait_upd("first", u1);
        chk("first_latency", u1 - c0, LAT);
        @(negedge clk);
        chk("upd_one_cycle", int'(disp_upd), 0);
        chk_sb_empty("first_sb");

        // Table of single-source conversions
        foreach (vecs[i]) begin
            do_reset();
            push_dig(0, vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].eovf);
            load(3'b001, vecs[i].val, 0, 0);
            c0 = cyc;
            wait_upd("vec", u1);
            chk("vec_latency", u1 - c0, LAT);
            chk_sb_empty("vec_sb");
        end

        // Rotation 0,1,2,0 with fixed period
        do_reset();
        push_val(0, 360); push_val(1, 45); push_val(2, 90); push_val(0, 360);
        load(3'b001, 360, 0, 0);
        wait_upd("rot1", u1);
        load(3'b110, 0, 45, 90);
        wait_upd("rot2", u2);
        wait_upd("rot3", u3);
        wait_upd("rot4", u4);
        chk("rot_gap12", u2 - u1, PER);
        chk("rot_gap23", u3 - u2, PER);
        chk("rot_gap34", u4 - u3, PER);
        chk_sb_empty("rot_sb");

        // Saturation then a small value on the same source
        do_reset();
        push_val(1, 1023);
        load(3'b010, 0, 1023, 0);
        wait_upd("sat1", u1);
        push_val(1, 5);
        load(3'b010, 0, 5, 0);
        wait_upd("sat2", u2);
        chk("sat_gap", u2 - u1, PER);
        chk_sb_empty("sat_sb");

        // Hold keeps src1 for three periods, then rotation resumes at src2
        do_reset();
        push_val(1, 45);
        load(3'b111, 360, 45, 90);
        wait_upd("hold1", u1);
        hold = 1'b1;
        push_val(1, 45); push_val(1, 45); push_val(2, 90);
        wait_upd("hold2", u2);
        wait_upd("hold3", u3);
        hold = 1'b0;
        wait_upd("hold4", u4);
        chk("hold_gap", u4 - u1, 3 * PER);
        chk_sb_empty("hold_sb");

        // New value arriving mid-conversion shows only in the next period
        do_reset();
        push_val(0, 200); push_val(0, 100);
        load(3'b001, 200, 0, 0);
        repeat (4) @(negedge clk);
        load(3'b001, 100, 0, 0);
        wait_upd("snap1", u1);
        wait_upd("snap2", u2);
        chk("snap_gap", u2 - u1, PER);
        chk_sb_empty("snap_sb");

        // Reset during conversion aborts everything
        do_reset();
        push_val(0, 360);
        load(3'b001, 360, 0, 0);
        repeat (5) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_bcd0", int'(bcd0), 0);
        chk("abort_bcd1", int'(bcd1), 0);
        chk("abort_bcd2", int'(bcd2), 0);
        chk("abort_src", int'(disp_src), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b0;
        c0 = upd_cnt;
        repeat (3 * PER) @(negedge clk);
        chk("abort_no_upd", upd_cnt - c0, 0);
        chk("abort_idle_busy", int'(busy), 0);
        push_val(2, 90);
        load(3'b100, 0, 0, 90);
        wait_upd("abort_new", u1);
        chk_sb_empty("abort_sb");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
